multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Sequencing control for the multicycle MIPS datapath: owns the instruction register and an FSM that
//  steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on cache hits. Adds sub-word
//  loads/stores (LBU/LHU/SB/SH) with byte enables, and a real LL/SC link register with snoop invalidate.
//  Sits between icache/dcache handshakes and the datapath muxes, regfile, ALU and PC.
// PARAMETERS
//  WORD_W          32  datapath/address width (>=32; opcode fields always from IR[31:0])
//  REGSEL_W        5   register select width
//  ENABLE_SUBWORD  1   1: LBU/LHU/SB/SH decoded; 0: treated as unknown opcodes (NOP)
//  ENABLE_ATOMIC   1   1: LL/SC with link register; 0: LL behaves as LW, SC as SW and writes 1 to rt
// PORTS
//  CLK         in   1         clock, rising edge
//  RST         in   1         async reset, active-high
//  instr       in   32        icache read data, valid when ihit
//  ihit/dhit   in   1 each    icache / dcache access complete this cycle
//  alu_out     in   WORD_W    datapath ALU result (memory address for loads/stores)
//  snoop_valid in   1         coherence invalidate seen this cycle
//  snoop_addr  in   WORD_W    invalidated address (word-compared, [1:0] ignored)
//  iREN        out  1         icache read request
//  dREN/dWEN   out  1 each    dcache read / write request
//  dbyteen     out  4         byte enables for dcache access
//  datomic     out  1         high during MEM of LL/SC
//  rsel1/rsel2/wsel out REGSEL_W  regfile selects from IR
//  immediate   out  WORD_W    extended immediate (sign/zero/LUI/shamt per opcode)
//  aluSrc      out  1         1: ALU op2 = immediate
//  ALUop       out  aluop_t   ALU operation
//  wdataSrc    out  2         00 ALU, 01 mem, 10 npc, 11 sc_result
//  regWrite    out  1         regfile write strobe, WB state only
//  PCSel       out  2         00 jump, 01 branch, 10 rs (JR), 11 npc
//  pcWEN       out  1         PC load strobe, one cycle per instruction
//  sc_result   out  1         SC outcome written via wdataSrc=11
//  halt        out  1         sticky halt
//  state       out  3         FSM state for debug: FETCH0 DECODE1 EXEC2 MEM3 WB4 HALTED5
// BEHAVIOUR
//  - RST (async): state=FETCH, IR=0 (SLL r0 = NOP), link_valid=0, halt=0; all strobes/selects 0,
//    PCSel=11. Reset mid-access abandons the request; no regWrite/pcWEN issued for it.
//  - Outputs are Moore: decoded from state and registered IR only, never from raw instr.
//  - FETCH: iREN=1 until ihit; on ihit IR<=instr, ->DECODE. iREN drops the cycle after ihit.
//  - DECODE: selects/immediate/ALUop valid; HALT opcode ->HALTED; else ->EXEC.
//  - EXEC: branch/J/JR: pcWEN=1 with PCSel, ->FETCH (3 cycles min). Loads/stores ->MEM.
//    JAL: ->WB (wdataSrc=10, wsel=31). ALU ops ->WB; pcWEN=1 (PCSel=11) in WB for non-jumps.
//  - MEM: dREN/dWEN held until dhit, ->WB (loads, SC) or ->FETCH with pcWEN (stores).
//  - WB: regWrite=1 for one cycle unless wsel==0 or op writes nothing; ->FETCH.
//  - Min latency: ALU 4, branch/jump 3, store 4, load 5 cycles + cache wait cycles.
//  - HALTED: halt=1, all strobes 0, remains until RST; ihit/dhit ignored.
//  - dbyteen: LW/SW/LL/SC=1111; byte: one-hot at alu_out[1:0]; half: alu_out[1]?1100:0011, [0] ignored.
//  - LL: on dhit link_addr<=alu_out[WORD_W-1:2], link_valid<=1.
//  - SC in EXEC: link_valid && match -> MEM with dWEN, sc_result=1; else skip MEM -> WB with
//    sc_result=0, no dWEN. Any SC clears link_valid in WB.
//  - snoop_valid with word match clears link_valid; same cycle as SC EXEC -> snoop wins, SC fails.
//    Snoop same cycle as LL dhit -> LL set wins (snoop precedes link).
//  - Unknown opcode/funct: no writes, pcWEN=1 with PCSel=11 in EXEC, ->FETCH.
// TESTING
//  - ADDIU r2,r0,5 with ihit at 1st FETCH cycle -> regWrite in cycle 4, wsel=2, pcWEN same cycle.
//  - LW with dhit delayed 3 cycles -> dREN high exactly 4 cycles, regWrite wdataSrc=01 one cycle later.
//  - SB to alu_out=0x...02 -> dbyteen=0100; SH to 0x...03 -> 1100; ENABLE_SUBWORD=0 -> no dWEN.
//  - LL 0x100, SC 0x100 -> dWEN, rt<=1; LL 0x100, snoop 0x102, SC 0x100 -> no dWEN, rt<=0.
//  - HALT then ihit pulses -> halt stays 1, iREN 0; RST asserted mid-MEM -> state=FETCH, no regWrite.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: instruction register, FETCH/DECODE/EXEC/MEM/WB
// sequencer with cache handshakes, sub-word byte enables and an LL/SC link register.
module multicycle_control_unit #(
  parameter int WORD_W         = 32,
  parameter int REGSEL_W       = 5,
  parameter int ENABLE_SUBWORD = 1,
  parameter int ENABLE_ATOMIC  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_i,
  input  logic                ihit_i,
  input  logic                dhit_i,
  input  logic [WORD_W-1:0]   alu_out_i,
  input  logic                snoop_valid_i,
  input  logic [WORD_W-1:0]   snoop_addr_i,
  output logic                iren_o,
  output logic                dren_o,
  output logic                dwen_o,
  output logic [3:0]          dbyteen_o,
  output logic                datomic_o,
  output logic [REGSEL_W-1:0] rsel1_o,
  output logic [REGSEL_W-1:0] rsel2_o,
  output logic [REGSEL_W-1:0] wsel_o,
  output logic [WORD_W-1:0]   immediate_o,
  output logic                alu_src_o,
  output logic [3:0]          alu_op_o,
  output logic [1:0]          wdata_src_o,
  output logic                reg_write_o,
  output logic [1:0]          pc_sel_o,
  output logic                pc_wen_o,
  output logic                sc_result_o,
  output logic                halt_o,
  output logic [2:0]          state_o
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  // Instruction classes driving the sequencer
  localparam logic [3:0] C_UNK = 4'd0, C_ALU = 4'd1, C_BR = 4'd2, C_J = 4'd3, C_JAL = 4'd4;
  localparam logic [3:0] C_JR = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7, C_LL = 4'd8, C_SC = 4'd9;
  localparam logic [3:0] C_HALT = 4'd10;

  localparam logic [1:0] SZ_WORD = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2;

  logic [2:0]          state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic                link_valid_q, link_valid_d;
  logic [WORD_W-3:0]   link_addr_q, link_addr_d;
  logic                sc_q, sc_d;

  logic [5:0]          opcode, funct;
  logic [REGSEL_W-1:0] rs_f, rt_f, rd_f, wsel_dec;
  logic [WORD_W-1:0]   imm_sext, imm_zext, imm_lui, imm_shamt, imm_dec;
  logic [3:0]          cls, alu_op_dec;
  logic                alu_src_dec;
  logic [1:0]          size_dec, wdata_dec;
  logic [3:0]          byteen;
  logic                snoop_match, sc_ok, decoded_window;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs_f      = REGSEL_W'(ir_q[25:21]);
  assign rt_f      = REGSEL_W'(ir_q[20:16]);
  assign rd_f      = REGSEL_W'(ir_q[15:11]);
  assign imm_sext  = {{(WORD_W-16){ir_q[15]}}, ir_q[15:0]};
  assign imm_zext  = {{(WORD_W-16){1'b0}}, ir_q[15:0]};
  assign imm_lui   = imm_zext << 16;
  assign imm_shamt = {{(WORD_W-5){1'b0}}, ir_q[10:6]};

  // Word-granular compare: low two address bits are forced equal on both sides
  assign snoop_match = snoop_valid_i && ((snoop_addr_i | WORD_W'(3)) == {link_addr_q, 2'b11});
  // A snoop hitting the link in the same cycle as SC evaluation makes the SC fail
  assign sc_ok = (ENABLE_ATOMIC == 0) ||
                 (link_valid_q && (alu_out_i[WORD_W-1:2] == link_addr_q) && !snoop_match);

  // Opcode/funct decode of the registered instruction
  always_comb begin
    cls         = C_UNK;
    alu_op_dec  = ALU_ADD;
    alu_src_dec = 1'b0;
    imm_dec     = imm_sext;
    wsel_dec    = rt_f;
    size_dec    = SZ_WORD;
    case (opcode)
      6'h00: begin
        wsel_dec = rd_f;
        cls      = C_ALU;
        case (funct)
          6'h00:        begin alu_op_dec = ALU_SLL; alu_src_dec = 1'b1; imm_dec = imm_shamt; end
          6'h02:        begin alu_op_dec = ALU_SRL; alu_src_dec = 1'b1; imm_dec = imm_shamt; end
          6'h08:        cls = C_JR;
          6'h20, 6'h21: alu_op_dec = ALU_ADD;
          6'h22, 6'h23: alu_op_dec = ALU_SUB;
          6'h24:        alu_op_dec = ALU_AND;
          6'h25:        alu_op_dec = ALU_OR;
          6'h26:        alu_op_dec = ALU_XOR;
          6'h27:        alu_op_dec = ALU_NOR;
          6'h2A:        alu_op_dec = ALU_SLT;
          6'h2B:        alu_op_dec = ALU_SLTU;
          default:      cls = C_UNK;
        endcase
      end
      6'h02:        cls = C_J;
      6'h03:        begin cls = C_JAL; wsel_dec = REGSEL_W'(31); end
      6'h04, 6'h05: begin cls = C_BR; alu_op_dec = ALU_SUB; end
      6'h08, 6'h09: begin cls = C_ALU; alu_src_dec = 1'b1; end
      6'h0A:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_SLT; end
      6'h0B:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_SLTU; end
      6'h0C:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_AND; imm_dec = imm_zext; end
      6'h0D:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_OR;  imm_dec = imm_zext; end
      6'h0E:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_XOR; imm_dec = imm_zext; end
      6'h0F:        begin cls = C_ALU; alu_src_dec = 1'b1; alu_op_dec = ALU_OR;  imm_dec = imm_lui;  end
      6'h23:        begin cls = C_LOAD;  alu_src_dec = 1'b1; end
      6'h24: if (ENABLE_SUBWORD != 0) begin cls = C_LOAD;  alu_src_dec = 1'b1; size_dec = SZ_BYTE; end
      6'h25: if (ENABLE_SUBWORD != 0) begin cls = C_LOAD;  alu_src_dec = 1'b1; size_dec = SZ_HALF; end
      6'h28: if (ENABLE_SUBWORD != 0) begin cls = C_STORE; alu_src_dec = 1'b1; size_dec = SZ_BYTE; end
      6'h29: if (ENABLE_SUBWORD != 0) begin cls = C_STORE; alu_src_dec = 1'b1; size_dec = SZ_HALF; end
      6'h2B:        begin cls = C_STORE; alu_src_dec = 1'b1; end
      6'h30:        begin cls = (ENABLE_ATOMIC != 0) ? C_LL : C_LOAD; alu_src_dec = 1'b1; end
      6'h38:        begin cls = C_SC; alu_src_dec = 1'b1; end
      6'h3F:        cls = C_HALT;
      default:      cls = C_UNK;
    endcase
  end

  // Byte enables from access size and the low address bits
  always_comb begin
    byteen = 4'b1111;
    if (size_dec == SZ_BYTE)      byteen = 4'b0001 << alu_out_i[1:0];
    else if (size_dec == SZ_HALF) byteen = alu_out_i[1] ? 4'b1100 : 4'b0011;
  end

  // Writeback source per class
  always_comb begin
    wdata_dec = 2'b00;
    if (cls == C_LOAD || cls == C_LL) wdata_dec = 2'b01;
    else if (cls == C_JAL)            wdata_dec = 2'b10;
    else if (cls == C_SC)             wdata_dec = 2'b11;
  end

  // Next-state, instruction capture, SC outcome and link register update
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    sc_d         = sc_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    case (state_q)
      ST_FETCH:  if (ihit_i) begin ir_d = instr_i; state_d = ST_DECODE; end
      ST_DECODE: state_d = (cls == C_HALT) ? ST_HALTED : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          C_LOAD, C_STORE, C_LL: state_d = ST_MEM;
          C_ALU, C_JAL:          state_d = ST_WB;
          C_SC: begin
            sc_d    = sc_ok;
            state_d = sc_ok ? ST_MEM : ST_WB;
          end
          default:               state_d = ST_FETCH;
        endcase
      end
      ST_MEM:    if (dhit_i) state_d = (cls == C_STORE) ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_HALTED;
    endcase
    // Ordering gives snoop < SC clear < LL set, so an LL completing alongside a snoop keeps its link
    if (snoop_match) link_valid_d = 1'b0;
    if (state_q == ST_WB && cls == C_SC) link_valid_d = 1'b0;
    if (state_q == ST_MEM && cls == C_LL && dhit_i) begin
      link_valid_d = 1'b1;
      link_addr_d  = alu_out_i[WORD_W-1:2];
    end
  end

  // State registers; reset abandons any in-flight access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      ir_q         <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      sc_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      sc_q         <= sc_d;
    end
  end

  assign decoded_window = !rst_i && (state_q == ST_DECODE || state_q == ST_EXEC ||
                                     state_q == ST_MEM || state_q == ST_WB);

  // Output decode from state and IR; only the store-completion PC strobe is qualified by dhit
  always_comb begin
    iren_o      = 1'b0;
    dren_o      = 1'b0;
    dwen_o      = 1'b0;
    dbyteen_o   = 4'b0000;
    datomic_o   = 1'b0;
    reg_write_o = 1'b0;
    pc_wen_o    = 1'b0;
    pc_sel_o    = 2'b11;
    rsel1_o     = '0;
    rsel2_o     = '0;
    wsel_o      = '0;
    immediate_o = '0;
    alu_src_o   = 1'b0;
    alu_op_o    = 4'd0;
    wdata_src_o = 2'b00;
    if (decoded_window) begin
      rsel1_o     = rs_f;
      rsel2_o     = rt_f;
      wsel_o      = wsel_dec;
      immediate_o = imm_dec;
      alu_src_o   = alu_src_dec;
      alu_op_o    = alu_op_dec;
      wdata_src_o = wdata_dec;
    end
    case (state_q)
      ST_FETCH: iren_o = !rst_i;
      ST_EXEC: begin
        case (cls)
          C_BR:  begin pc_wen_o = 1'b1; pc_sel_o = 2'b01; end
          C_J:   begin pc_wen_o = 1'b1; pc_sel_o = 2'b00; end
          C_JR:  begin pc_wen_o = 1'b1; pc_sel_o = 2'b10; end
          C_UNK: begin pc_wen_o = 1'b1; pc_sel_o = 2'b11; end
          default: ;
        endcase
      end
      ST_MEM: begin
        dren_o    = (cls == C_LOAD) || (cls == C_LL);
        dwen_o    = (cls == C_STORE) || (cls == C_SC);
        dbyteen_o = byteen;
        datomic_o = (ENABLE_ATOMIC != 0) && ((cls == C_LL) || (cls == C_SC));
        pc_wen_o  = (cls == C_STORE) && dhit_i;
      end
      ST_WB: begin
        reg_write_o = (wsel_dec != '0);
        pc_wen_o    = 1'b1;
        pc_sel_o    = (cls == C_JAL) ? 2'b00 : 2'b11;
      end
      default: ;
    endcase
  end

  assign sc_result_o = sc_q;
  assign halt_o      = (state_q == ST_HALTED);
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: second instance built without sub-word ops.
module tb_multicycle_control_unit;

  localparam logic [31:0] I_ADDIU = 32'h2402_0005;  // addiu r2,r0,5
  localparam logic [31:0] I_LW    = 32'h8C23_0000;  // lw r3,0(r1)
  localparam logic [31:0] I_SB    = 32'hA024_0000;  // sb r4,0(r1)
  localparam logic [31:0] I_SH    = 32'hA424_0000;  // sh r4,0(r1)
  localparam logic [31:0] I_LL    = 32'hC025_0000;  // ll r5,0(r1)
  localparam logic [31:0] I_SC    = 32'hE025_0000;  // sc r5,0(r1)
  localparam logic [31:0] I_BEQ   = 32'h1022_0004;  // beq r1,r2,4
  localparam logic [31:0] I_HALT  = 32'hFC00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ihit, ihit_ns, dhit, snoop_valid;
  logic [31:0] instr, alu_out, snoop_addr;

  logic        iren, dren, dwen, datomic, alu_src, reg_write, pc_wen, sc_result, halt;
  logic [3:0]  dbyteen, alu_op;
  logic [4:0]  rsel1, rsel2, wsel;
  logic [31:0] immediate;
  logic [1:0]  wdata_src, pc_sel;
  logic [2:0]  state;

  logic        ns_iren, ns_dren, ns_dwen, ns_datomic, ns_alu_src, ns_reg_write, ns_pc_wen;
  logic        ns_sc_result, ns_halt;
  logic [3:0]  ns_dbyteen, ns_alu_op;
  logic [4:0]  ns_rsel1, ns_rsel2, ns_wsel;
  logic [31:0] ns_immediate;
  logic [1:0]  ns_wdata_src, ns_pc_sel;
  logic [2:0]  ns_state;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .ihit_i(ihit), .dhit_i(dhit),
    .alu_out_i(alu_out), .snoop_valid_i(snoop_valid), .snoop_addr_i(snoop_addr),
    .iren_o(iren), .dren_o(dren), .dwen_o(dwen), .dbyteen_o(dbyteen), .datomic_o(datomic),
    .rsel1_o(rsel1), .rsel2_o(rsel2), .wsel_o(wsel), .immediate_o(immediate),
    .alu_src_o(alu_src), .alu_op_o(alu_op), .wdata_src_o(wdata_src), .reg_write_o(reg_write),
    .pc_sel_o(pc_sel), .pc_wen_o(pc_wen), .sc_result_o(sc_result), .halt_o(halt), .state_o(state)
  );

  multicycle_control_unit #(.ENABLE_SUBWORD(0)) u_nosub (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .ihit_i(ihit_ns), .dhit_i(dhit),
    .alu_out_i(alu_out), .snoop_valid_i(snoop_valid), .snoop_addr_i(snoop_addr),
    .iren_o(ns_iren), .dren_o(ns_dren), .dwen_o(ns_dwen), .dbyteen_o(ns_dbyteen),
    .datomic_o(ns_datomic), .rsel1_o(ns_rsel1), .rsel2_o(ns_rsel2), .wsel_o(ns_wsel),
    .immediate_o(ns_immediate), .alu_src_o(ns_alu_src), .alu_op_o(ns_alu_op),
    .wdata_src_o(ns_wdata_src), .reg_write_o(ns_reg_write), .pc_sel_o(ns_pc_sel),
    .pc_wen_o(ns_pc_wen), .sc_result_o(ns_sc_result), .halt_o(ns_halt), .state_o(ns_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // FETCH with ihit, then DECODE with instr scrambled so only the IR can supply the fields
  task automatic issue(input logic [31:0] ins, input string name, input bit also_ns);
    cyc(); instr = ins; ihit = 1'b1; ihit_ns = also_ns; #1;
    chk({name, ":fetch_state"}, 32'(state), 32'd0);
    chk({name, ":fetch_iren"}, 32'(iren), 32'd1);
    cyc(); ihit = 1'b0; ihit_ns = 1'b0; instr = 32'hFFFF_FFFF; #1;
    chk({name, ":decode_state"}, 32'(state), 32'd1);
    $display("txn %s instr=%08h t=%0t", name, ins, $time);
  endtask

  task automatic do_ll(input bit snoop_same, input string name);
    issue(I_LL, name, 1'b0);
    cyc(); alu_out = 32'h100;
    cyc(); dhit = 1'b1; snoop_valid = snoop_same; snoop_addr = 32'h100; #1;
    chk({name, ":datomic"}, 32'(datomic), 32'd1);
    chk({name, ":dren"}, 32'(dren), 32'd1);
    cyc(); dhit = 1'b0; snoop_valid = 1'b0; #1;
    chk({name, ":wb_regwrite"}, 32'(reg_write), 32'd1);
    chk({name, ":wb_wdata"}, 32'(wdata_src), 32'd1);
  endtask

  task automatic do_sc(input bit snoop_exec, input bit exp_ok, input string name);
    issue(I_SC, name, 1'b0);
    cyc(); alu_out = 32'h100; snoop_valid = snoop_exec; snoop_addr = 32'h100; #1;
    chk({name, ":exec_state"}, 32'(state), 32'd2);
    cyc(); snoop_valid = 1'b0; #1;
    if (exp_ok) begin
      chk({name, ":mem_state"}, 32'(state), 32'd3);
      chk({name, ":mem_dwen"}, 32'(dwen), 32'd1);
      chk({name, ":mem_datomic"}, 32'(datomic), 32'd1);
      dhit = 1'b1;
      cyc(); dhit = 1'b0; #1;
    end else begin
      chk({name, ":no_dwen"}, 32'(dwen), 32'd0);
    end
    chk({name, ":wb_state"}, 32'(state), 32'd4);
    chk({name, ":sc_result"}, 32'(sc_result), 32'(exp_ok));
    chk({name, ":wb_regwrite"}, 32'(reg_write), 32'd1);
    chk({name, ":wb_wdata"}, 32'(wdata_src), 32'd3);
    chk({name, ":wb_wsel"}, 32'(wsel), 32'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dren_cnt;
    rst = 1'b1; ihit = 1'b0; ihit_ns = 1'b0; dhit = 1'b0; snoop_valid = 1'b0;
    instr = '0; alu_out = '0; snoop_addr = '0;

    // Reset values
    cyc(); #1;
    chk("rst:state", 32'(state), 32'd0);
    chk("rst:iren", 32'(iren), 32'd0);
    chk("rst:pc_wen", 32'(pc_wen), 32'd0);
    chk("rst:reg_write", 32'(reg_write), 32'd0);
    chk("rst:pc_sel", 32'(pc_sel), 32'd3);
    chk("rst:halt", 32'(halt), 32'd0);
    chk("rst:alu_src", 32'(alu_src), 32'd0);
    cyc(); rst = 1'b0; #1;
    chk("rel:iren", 32'(iren), 32'd1);

    // ADDIU r2,r0,5: regWrite in cycle 4
    issue(I_ADDIU, "addiu", 1'b0);
    chk("addiu:wsel", 32'(wsel), 32'd2);
    chk("addiu:imm", immediate, 32'd5);
    chk("addiu:alu_src", 32'(alu_src), 32'd1);
    chk("addiu:alu_op", 32'(alu_op), 32'd2);
    cyc(); #1;
    chk("addiu:exec_state", 32'(state), 32'd2);
    chk("addiu:exec_regwrite", 32'(reg_write), 32'd0);
    cyc(); #1;
    chk("addiu:wb_regwrite", 32'(reg_write), 32'd1);
    chk("addiu:wb_wsel", 32'(wsel), 32'd2);
    chk("addiu:wb_pc_wen", 32'(pc_wen), 32'd1);
    chk("addiu:wb_pc_sel", 32'(pc_sel), 32'd3);

    // LW with dhit on the 4th MEM cycle
    issue(I_LW, "lw", 1'b0);
    cyc(); #1;
    chk("lw:exec_dren", 32'(dren), 32'd0);
    dren_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); alu_out = 32'h100; dhit = (i == 3); #1;
      if (dren) dren_cnt++;
      chk("lw:mem_state", 32'(state), 32'd3);
    end
    cyc(); dhit = 1'b0; #1;
    if (dren) dren_cnt++;
    chk("lw:dren_cycles", 32'(dren_cnt), 32'd4);
    chk("lw:wb_regwrite", 32'(reg_write), 32'd1);
    chk("lw:wb_wdata", 32'(wdata_src), 32'd1);
    chk("lw:wb_wsel", 32'(wsel), 32'd3);

    // SB to ...02; the no-subword instance sees SB as unknown
    issue(I_SB, "sb", 1'b1);
    cyc(); #1;
    chk("sb:exec_pc_wen", 32'(pc_wen), 32'd0);
    chk("sb_nosub:exec_state", 32'(ns_state), 32'd2);
    chk("sb_nosub:exec_pc_wen", 32'(ns_pc_wen), 32'd1);
    chk("sb_nosub:exec_pc_sel", 32'(ns_pc_sel), 32'd3);
    cyc(); alu_out = 32'h102; dhit = 1'b1; #1;
    chk("sb:mem_dwen", 32'(dwen), 32'd1);
    chk("sb:dbyteen", 32'(dbyteen), 32'b0100);
    chk("sb:mem_pc_wen", 32'(pc_wen), 32'd1);
    chk("sb_nosub:state", 32'(ns_state), 32'd0);
    chk("sb_nosub:dwen", 32'(ns_dwen), 32'd0);
    cyc(); dhit = 1'b0; #1;
    chk("sb:after_state", 32'(state), 32'd0);
    chk("sb:after_regwrite", 32'(reg_write), 32'd0);

    // SH to ...03
    issue(I_SH, "sh", 1'b0);
    cyc();
    cyc(); alu_out = 32'h103; dhit = 1'b1; #1;
    chk("sh:mem_dwen", 32'(dwen), 32'd1);
    chk("sh:dbyteen", 32'(dbyteen), 32'b1100);
    cyc(); dhit = 1'b0;

    // LL/SC pairs
    do_ll(1'b0, "ll_a");
    do_sc(1'b0, 1'b1, "sc_ok");
    do_sc(1'b0, 1'b0, "sc_nolink");
    do_ll(1'b1, "ll_snoop_same");
    do_sc(1'b0, 1'b1, "sc_after_ll_snoop");
    do_ll(1'b0, "ll_b");
    cyc(); snoop_valid = 1'b1; snoop_addr = 32'h102;
    cyc(); snoop_valid = 1'b0;
    do_sc(1'b0, 1'b0, "sc_snooped");
    do_ll(1'b0, "ll_c");
    do_sc(1'b1, 1'b0, "sc_snoop_exec");

    // Branch: 3 cycles
    issue(I_BEQ, "beq", 1'b0);
    cyc(); #1;
    chk("beq:exec_pc_wen", 32'(pc_wen), 32'd1);
    chk("beq:exec_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq:alu_op", 32'(alu_op), 32'd3);
    cyc(); #1;
    chk("beq:next_state", 32'(state), 32'd0);

    // HALT, then ihit pulses are ignored
    issue(I_HALT, "halt", 1'b0);
    cyc(); #1;
    chk("halt:state", 32'(state), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(); ihit = 1'b1; dhit = 1'b1; #1;
      chk("halt:sticky", 32'(halt), 32'd1);
      chk("halt:iren", 32'(iren), 32'd0);
    end
    ihit = 1'b0; dhit = 1'b0;
    cyc(); rst = 1'b1; #1;
    chk("halt_rst:halt", 32'(halt), 32'd0);
    cyc(); rst = 1'b0;

    // Reset asserted mid-MEM
    issue(I_LW, "lw_rst", 1'b0);
    cyc();
    cyc(); #1;
    chk("lw_rst:mem_dren", 32'(dren), 32'd1);
    #2 rst = 1'b1; #1;
    chk("lw_rst:state", 32'(state), 32'd0);
    chk("lw_rst:dren", 32'(dren), 32'd0);
    cyc(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); dhit = 1'b1; #1;
      chk("lw_rst:no_regwrite", 32'(reg_write), 32'd0);
      chk("lw_rst:fetch_state", 32'(state), 32'd0);
    end
    dhit = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
